// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan controller: hex glyph table,
// the all-dark segment pattern and the brightness field width.
package seg_pkg;

   localparam int BRIGHT_W = 4;
   localparam logic [7:0] SEG_OFF = 8'hFF;

   // Active-low g..a patterns, indexed by nibble value
   localparam logic [6:0] HEX_TBL [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Display-side bundle for seg_scan_ctrl: digit data/controls in,
// multiplexed anode/segment drive and frame marker out.
interface seg_scan_ctrl_if #(
   parameter int NUM_DIGITS = 4
);
   import seg_pkg::*;

   logic [4*NUM_DIGITS-1:0] digit;
   logic [NUM_DIGITS-1:0]   dp;
   logic [NUM_DIGITS-1:0]   blank;
   logic [BRIGHT_W-1:0]     bright;
   logic [NUM_DIGITS-1:0]   anode;
   logic [7:0]              segment;
   logic                    frame_start;

   modport master (
      output digit, dp, blank, bright,
      input  anode, segment, frame_start
   );

   modport slave (
      input  digit, dp, blank, bright,
      output anode, segment, frame_start
   );

endinterface

// File: rtl/seg_hex_decode.sv
// Combinational nibble to active-low g..a segment pattern.
module seg_hex_decode
   import seg_pkg::*;
(
   input  logic [3:0] nib,
   output logic [6:0] seg
);

   assign seg = HEX_TBL[nib];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scanner with frame-synchronous shadow capture,
// anti-ghost dead time and PWM brightness. Optional: LEAD_ZERO_SUPPRESS_EN.
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int NUM_DIGITS   = 4,
   parameter int SLOT_W       = 14,
   parameter int BLANK_CYCLES = 256
) (
   input  logic            clk,
   input  logic            rst,
   seg_scan_ctrl_if.slave  bus
);

   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   logic [SLOT_W-1:0]           cnt;
   logic [IDX_W-1:0]            idx;
   logic                        init_pend;
   logic [NUM_DIGITS-1:0][3:0]  sh_digit;
   logic [NUM_DIGITS-1:0]       sh_dp;
   logic [NUM_DIGITS-1:0]       sh_blank;
   logic [NUM_DIGITS-1:0]       anode_q;
   logic [7:0]                  seg_q;

   logic                        cnt_max;
   logic                        idx_last;
   logic                        cap;
   logic [NUM_DIGITS-1:0]       dark;
   logic                        lit;
   logic [6:0]                  hex;
   logic [NUM_DIGITS-1:0]       anode_d;
   logic [7:0]                  seg_d;

   assign cnt_max  = &cnt;
   assign idx_last = (idx == IDX_W'(NUM_DIGITS - 1));
   // init_pend forces one capture right after reset so the display never
   // waits a whole frame to pick up its first value
   assign cap      = init_pend | (cnt_max & idx_last);

   assign bus.frame_start = cap & ~rst;

`ifdef LEAD_ZERO_SUPPRESS_EN
   for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_lz
      if (i == 0) begin : g_d0
         assign dark[i] = sh_blank[i];
      end else begin : g_dn
         assign dark[i] = sh_blank[i] |
                          (~sh_dp[i] & (sh_digit[NUM_DIGITS-1:i] == '0));
      end
   end
`else
   assign dark = sh_blank;
`endif

   seg_hex_decode u_dec (
      .nib (sh_digit[idx]),
      .seg (hex)
   );

   always_comb begin
      lit     = (cnt >= SLOT_W'(BLANK_CYCLES)) &&
                (cnt[SLOT_W-1 -: BRIGHT_W] <= bus.bright) &&
                !dark[idx];
      anode_d = '1;
      seg_d   = SEG_OFF;
      if (lit) begin
         anode_d[idx] = 1'b0;
         seg_d        = {~sh_dp[idx], hex};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         idx       <= '0;
         init_pend <= 1'b1;
         sh_digit  <= '0;
         sh_dp     <= '0;
         sh_blank  <= '0;
         anode_q   <= '1;
         seg_q     <= SEG_OFF;
      end else begin
         cnt       <= cnt + 1'b1;
         init_pend <= 1'b0;
         if (cnt_max) idx <= idx_last ? '0 : idx + 1'b1;
         if (cap) begin
            sh_digit <= bus.digit;
            sh_dp    <= bus.dp;
            sh_blank <= bus.blank;
         end
         anode_q <= anode_d;
         seg_q   <= seg_d;
      end
   end

   assign bus.anode   = anode_q;
   assign bus.segment = seg_q;

endmodule
